// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared IEEE-754 single-precision constants, FSM states and field layout
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;
endpackage

// File: rtl/ieee754_mant_divider.sv
// rtl/ieee754_mant_divider.sv - one radix-2 restoring division step on 24-bit significands
module ieee754_mant_divider
  import fpu_pkg::*;
(
  input  logic [MAN_W+1:0] r,
  input  logic [MAN_W:0]   mb,
  output logic [MAN_W+1:0] r_next,
  output logic             q_bit
);
  logic [MAN_W:0] diff;

  always_comb begin
    q_bit  = r >= {1'b0, mb};
    // r < 2*mb always holds, so the partial remainder fits in 24 bits either way
    diff   = q_bit ? (r[MAN_W:0] - mb) : r[MAN_W:0];
    r_next = {diff, 1'b0};
  end
endmodule

// File: rtl/ieee754_fpu_divider.sv
// rtl/ieee754_fpu_divider.sv - sequential IEEE-754 single-precision divider (a / b), denormals flushed
// Define FPU_DIV_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module ieee754_fpu_divider
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);
  localparam int               SIG_W     = MAN_W + 1;
  localparam int               Q_W       = MAN_W + 3;
  localparam logic [4:0]       LAST_STEP = 5'(Q_W - 1);
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;

  fp32_t op_a, op_b;
  logic  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_in;

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [9:0]       e_q, e_d;
  logic [SIG_W-1:0] mb_q, mb_d;
  logic [SIG_W:0]   r_q, r_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic [3:0]       flags_q, flags_d;  // {overflow, underflow, div_by_zero, invalid}

  logic [SIG_W:0]   r_step;
  logic             q_bit;
  logic [9:0]       e_n, e_r;
  logic [SIG_W-1:0] sig;
  logic [SIG_W:0]   sig_r;
  logic [MAN_W-1:0] frac_r;
`ifdef FPU_DIV_RNE_EN
  logic             guard, sticky;
`endif

  assign op_a    = a;
  assign op_b    = b;
  assign a_zero  = op_a.exp == '0;
  assign a_inf   = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
  assign a_nan   = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
  assign b_zero  = op_b.exp == '0;
  assign b_inf   = (op_b.exp == EXP_MAX) && (op_b.frac == '0);
  assign b_nan   = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
  assign sign_in = op_a.sign ^ op_b.sign;

  ieee754_mant_divider u_step (
    .r      (r_q),
    .mb     (mb_q),
    .r_next (r_step),
    .q_bit  (q_bit)
  );

  // A quotient below 1.0 leaves q[Q_W-1] clear and needs one left shift.
  always_comb begin
    e_n = q_q[Q_W-1] ? e_q : e_q - 10'd1;
    sig = q_q[Q_W-1] ? q_q[Q_W-1:2] : q_q[Q_W-2:1];
`ifdef FPU_DIV_RNE_EN
    guard  = q_q[Q_W-1] ? q_q[1] : q_q[0];
    sticky = (|r_q) | (q_q[Q_W-1] & q_q[0]);
    sig_r  = {1'b0, sig} + {{SIG_W{1'b0}}, guard & (sticky | sig[0])};
`else
    sig_r  = {1'b0, sig};
`endif
    e_r    = e_n + {9'd0, sig_r[SIG_W]};
    frac_r = sig_r[SIG_W] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    e_d      = e_q;
    mb_d     = mb_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sign_d  = sign_in;
        e_d     = {2'b00, op_a.exp} - {2'b00, op_b.exp} + 10'(BIAS);
        mb_d    = {1'b1, op_b.frac};
        r_d     = {2'b01, op_a.frac};
        q_d     = '0;
        cnt_d   = '0;
        state_d = DONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = QNAN;
          flags_d  = 4'b0001;
        end else if (a_inf) begin
          result_d = POS_INF | {sign_in, 31'd0};
          flags_d  = 4'b0000;
        end else if (b_zero) begin
          result_d = POS_INF | {sign_in, 31'd0};
          flags_d  = 4'b0010;
        end else if (a_zero || b_inf) begin
          result_d = {sign_in, 31'd0};
          flags_d  = 4'b0000;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        r_d   = r_step;
        q_d   = {q_q[Q_W-2:0], q_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) state_d = NORM;
      end
      NORM: begin
        state_d = DONE;
        if ($signed(e_r) >= 10'sd255) begin
          result_d = POS_INF | {sign_q, 31'd0};
          flags_d  = 4'b1000;
        end else if ($signed(e_r) <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = 4'b0100;
        end else begin
          result_d = {sign_q, e_r[EXP_W-1:0], frac_r};
          flags_d  = 4'b0000;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      e_q      <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign result      = result_q;
  assign overflow    = flags_q[3];
  assign underflow   = flags_q[2];
  assign div_by_zero = flags_q[1];
  assign invalid     = flags_q[0];
endmodule
